// File: rtl/riscv_pkg.sv
// Shared RV64I pipeline definitions: fetch-stage FSM encoding and the canonical NOP.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    DROP
  } fstage_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] RISCV_NOP = 32'h00000013;

endpackage

// File: rtl/riscv_fstage_ifid.sv
// IF/ID pipeline register: flush beats stall beats load; otherwise a bubble is inserted.
module riscv_fstage_ifid
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [31:0]     inst_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      inst    <= RISCV_NOP;
      pc      <= '0;
      pcplus4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      inst  <= RISCV_NOP;
    end else if (stall) begin
      valid <= valid;
    end else if (load) begin
      valid   <= 1'b1;
      inst    <= inst_in;
      pc      <= pc_in;
      pcplus4 <= pc_in + XLEN'(4);
    end else begin
      // bubble keeps pc/pcplus4 so decode still sees the last address
      valid <= 1'b0;
      inst  <= RISCV_NOP;
    end
  end

endmodule

// File: rtl/riscv_fstage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem request FSM and IF/ID drive.
// state | meaning
// IDLE  | out of reset, first request issued next cycle
// FETCH | request for pc_q on the bus this cycle
// WAIT  | request outstanding, waiting for the response
// HOLD  | response buffered, decode stalled
// DROP  | redirected while outstanding; discard the stale response
module riscv_fstage
  import riscv_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            i_riscv_clk,
  input  logic            i_riscv_rst,
  output logic            o_riscv_fstage_imem_req,
  output logic [XLEN-1:0] o_riscv_fstage_imem_addr,
  input  logic            i_riscv_fstage_imem_valid,
  input  logic [31:0]     i_riscv_fstage_imem_rdata,
  input  logic            i_riscv_fstage_stall,
  input  logic            i_riscv_fstage_redirect,
  input  logic [XLEN-1:0] i_riscv_fstage_pctarget,
  output logic            o_riscv_fstage_valid,
  output logic [31:0]     o_riscv_fstage_inst,
  output logic [XLEN-1:0] o_riscv_fstage_pc,
  output logic [XLEN-1:0] o_riscv_fstage_pcplus4
);

  fstage_state_e   state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target;
  logic [31:0]     inst_buf_q;
  logic [31:0]     deliver_inst;
  logic            req, deliver, buf_load;
  logic            redirect, stall, mem_valid;

  assign redirect     = i_riscv_fstage_redirect;
  assign stall        = i_riscv_fstage_stall;
  assign mem_valid    = i_riscv_fstage_imem_valid;
  assign target       = i_riscv_fstage_pctarget & ~XLEN'(3);
  assign deliver_inst = (state_q == HOLD) ? inst_buf_q : i_riscv_fstage_imem_rdata;

  always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
    if (i_riscv_rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      inst_buf_q <= RISCV_NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (buf_load) inst_buf_q <= i_riscv_fstage_imem_rdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req      = 1'b0;
    deliver  = 1'b0;
    buf_load = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        req = !redirect;
        if (redirect) pc_d = target;
        else if (mem_valid) begin
          if (!stall) deliver = 1'b1;
          else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end else state_d = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = mem_valid ? FETCH : DROP;
        end else if (mem_valid) begin
          if (!stall) deliver = 1'b1;
          else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall) deliver = 1'b1;
      end
      DROP: begin
        if (redirect) pc_d = target;
        if (mem_valid) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (deliver) begin
      pc_d    = pc_q + XLEN'(4);
      state_d = FETCH;
    end
  end

  assign o_riscv_fstage_imem_req  = req;
  assign o_riscv_fstage_imem_addr = pc_q;

  riscv_fstage_ifid #(.XLEN(XLEN)) u_ifid (
    .clk     (i_riscv_clk),
    .rst     (i_riscv_rst),
    .flush   (redirect),
    .stall   (stall),
    .load    (deliver),
    .inst_in (deliver_inst),
    .pc_in   (pc_q),
    .valid   (o_riscv_fstage_valid),
    .inst    (o_riscv_fstage_inst),
    .pc      (o_riscv_fstage_pc),
    .pcplus4 (o_riscv_fstage_pcplus4)
  );

endmodule

// File: tb/tb_riscv_fstage.sv
// Directed bench for riscv_fstage: throughput, latency, stall, redirect, wrap and async reset.
module tb_riscv_fstage;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;
  logic            stall, redirect;
  logic [XLEN-1:0] pctarget;
  logic            if_valid;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc, if_pcplus4;

  logic            auto0, man_valid;
  logic [31:0]     man_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return 32'h1357_0000 ^ a[31:0] ^ a[63:32];
  endfunction

  // auto0 = zero-latency memory answering every request; otherwise the bench drives the bus
  assign imem_valid = auto0 ? imem_req : man_valid;
  assign imem_rdata = auto0 ? word_at(imem_addr) : man_rdata;

  riscv_fstage #(.XLEN(XLEN), .RESET_VECTOR(64'h0)) dut (
    .i_riscv_clk               (clk),
    .i_riscv_rst               (rst),
    .o_riscv_fstage_imem_req   (imem_req),
    .o_riscv_fstage_imem_addr  (imem_addr),
    .i_riscv_fstage_imem_valid (imem_valid),
    .i_riscv_fstage_imem_rdata (imem_rdata),
    .i_riscv_fstage_stall      (stall),
    .i_riscv_fstage_redirect   (redirect),
    .i_riscv_fstage_pctarget   (pctarget),
    .o_riscv_fstage_valid      (if_valid),
    .o_riscv_fstage_inst       (if_inst),
    .o_riscv_fstage_pc         (if_pc),
    .o_riscv_fstage_pcplus4    (if_pcplus4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] inst, input logic [63:0] pc);
    chk({tag, ".valid"},   64'(if_valid),   64'd1);
    chk({tag, ".inst"},    64'(if_inst),    64'(inst));
    chk({tag, ".pc"},      if_pc,           pc);
    chk({tag, ".pcplus4"}, if_pcplus4,      pc + 64'd4);
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [63:0] addr);
    chk({tag, ".req"}, 64'(imem_req), 64'(req));
    if (req) chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 64'(if_valid), 64'd0);
    chk({tag, ".inst"},  64'(if_inst),  64'(NOP));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; pctarget = '0;
    auto0 = 1'b0; man_valid = 1'b0; man_rdata = '0;
    #2;
    chk_req("rst", 1'b0, 64'h0);
    chk_bubble("rst");
    chk("rst.pc", if_pc, 64'h0);
    chk("rst.pcplus4", if_pcplus4, 64'h0);

    // zero-latency memory: first request on edge 1, first valid after edge 2
    @(negedge clk);
    auto0 = 1'b1;
    rst = 1'b0;
    #1 chk_req("idle", 1'b0, 64'h0);
    tick();
    chk_req("first", 1'b1, 64'h0);
    chk("first.valid", 64'(if_valid), 64'd0);
    tick();
    chk_ifid("z0", word_at(64'h0), 64'h0);
    chk_req("z0", 1'b1, 64'h4);
    tick();
    chk_ifid("z1", word_at(64'h4), 64'h4);
    chk_req("z1", 1'b1, 64'h8);

    // response for 0x8 arrives under stall -> HOLD with IF/ID frozen
    auto0 = 1'b0; man_valid = 1'b1; man_rdata = 32'hCAFE_0008; stall = 1'b1;
    #1 chk_req("st.req", 1'b1, 64'h8);
    tick();
    man_valid = 1'b0;
    #1 chk_req("hold0", 1'b0, 64'h0);
    chk_ifid("hold0", word_at(64'h4), 64'h4);
    tick();
    chk_req("hold1", 1'b0, 64'h0);
    chk_ifid("hold1", word_at(64'h4), 64'h4);
    stall = 1'b0;
    #1 chk_req("hold2", 1'b0, 64'h0);
    tick();
    chk_ifid("unstall", 32'hCAFE_0008, 64'h8);
    chk_req("unstall", 1'b1, 64'hC);

    // latency 3: one request and one valid instruction per four cycles
    for (int n = 0; n < 3; n++) begin
      logic [63:0] a;
      a = 64'hC + 64'(4 * n);
      chk_req("l3.fetch", 1'b1, a);
      tick();
      chk_req("l3.w1", 1'b0, 64'h0);
      chk("l3.w1.valid", 64'(if_valid), 64'd0);
      tick();
      chk_req("l3.w2", 1'b0, 64'h0);
      tick();
      man_valid = 1'b1; man_rdata = word_at(a);
      #1 chk_req("l3.w3", 1'b0, 64'h0);
      chk("l3.w3.valid", 64'(if_valid), 64'd0);
      tick();
      man_valid = 1'b0;
      #1 chk_ifid("l3.dlv", word_at(a), a);
    end

    // redirect while WAIT -> DROP, stale word discarded
    chk_req("rw.fetch", 1'b1, 64'h18);
    tick();
    redirect = 1'b1; pctarget = 64'h100;
    #1 chk_req("rw.redir", 1'b0, 64'h0);
    tick();
    redirect = 1'b0;
    #1 chk_bubble("rw.flush");
    chk_req("rw.drop0", 1'b0, 64'h0);
    tick();
    man_valid = 1'b1; man_rdata = 32'hDEAD_0018;
    #1 chk_req("rw.drop1", 1'b0, 64'h0);
    tick();
    man_valid = 1'b0;
    #1 chk_bubble("rw.stale");
    chk_req("rw.target", 1'b1, 64'h100);

    man_valid = 1'b1; man_rdata = word_at(64'h100);
    tick();
    man_valid = 1'b0;
    #1 chk_ifid("t100", word_at(64'h100), 64'h100);
    chk_req("t100", 1'b1, 64'h104);

    // redirect and stall together: redirect wins, low bits of target dropped
    stall = 1'b1; redirect = 1'b1; pctarget = 64'h203;
    #1 chk_req("rs.redir", 1'b0, 64'h0);
    tick();
    stall = 1'b0; redirect = 1'b0;
    #1 chk_bubble("rs.flush");
    chk_req("rs.target", 1'b1, 64'h200);

    auto0 = 1'b1;
    tick();
    chk_ifid("z200", word_at(64'h200), 64'h200);
    tick();
    chk_ifid("z204", word_at(64'h204), 64'h204);
    chk_req("z204", 1'b1, 64'h208);

    // PC wrap at the top of the address space
    redirect = 1'b1; pctarget = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 chk_req("wrap.redir", 1'b0, 64'h0);
    tick();
    redirect = 1'b0;
    #1 chk_req("wrap.fetch", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.flush", 64'(if_valid), 64'd0);
    tick();
    chk_ifid("wrap", word_at(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.pcplus4", if_pcplus4, 64'h0);
    chk_req("wrap.next", 1'b1, 64'h0);

    // async reset while a request is outstanding
    auto0 = 1'b0;
    tick();
    chk_req("ar.wait", 1'b0, 64'h0);
    #2 rst = 1'b1;
    #1 chk_req("ar", 1'b0, 64'h0);
    chk_bubble("ar");
    chk("ar.pc", if_pc, 64'h0);
    chk("ar.pcplus4", if_pcplus4, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; man_valid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    #1 chk_req("ar.idle", 1'b0, 64'h0);
    tick();
    man_valid = 1'b0;
    #1 chk_req("ar.first", 1'b1, 64'h0);
    chk("ar.first.valid", 64'(if_valid), 64'd0);
    man_valid = 1'b1; man_rdata = word_at(64'h0);
    tick();
    man_valid = 1'b0;
    #1 chk_ifid("ar.dlv", word_at(64'h0), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
